wb_serial_master: RTL and testbench

// - Byte-stream-driven Wishbone bus master for debug and boot loading: host sends framed read/write commands, block runs one bus cycle per frame.
// - Initiator end of the bus; drives the data-bus decoder in place of the CPU master port.
// - Byte stream is the rx/tx side of a UART: rx bytes are strobed in, tx bytes are offered under a valid/ready handshake.

---
 rtl/wb_serial_master.sv | 169 ++++++++++++++++
 tb/tb_wb_serial_master.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_serial_master.sv
// Byte-stream driven Wishbone master: host frames ('W'/'R' + address [+ data]) become
// single classic bus cycles, answered with 'K', four read data bytes, or 'E' on bus timeout.
module wb_serial_master #(
   parameter int BUS_TIMEOUT  = 1024,
   parameter int BYTE_TIMEOUT = 100000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   output logic        wb_cyc_o,
   output logic        wb_stb_o,
   output logic        wb_we_o,
   output logic [3:0]  wb_sel_o,
   output logic [31:0] wb_adr_o,
   output logic [31:0] wb_dat_o,
   input  logic [31:0] wb_dat_i,
   input  logic        wb_ack_i,
   input  logic        rx_valid_i,
   input  logic [7:0]  rx_data_i,
   output logic        tx_valid_o,
   output logic [7:0]  tx_data_o,
   input  logic        tx_ready_i,
   output logic        busy_o
);

   localparam int BusW = (BUS_TIMEOUT > 2) ? $clog2(BUS_TIMEOUT) : 1;
   localparam int GapW = (BYTE_TIMEOUT > 2) ? $clog2(BYTE_TIMEOUT) : 1;

   localparam logic [7:0] CmdWrite = 8'h57;
   localparam logic [7:0] CmdRead  = 8'h52;
   localparam logic [7:0] RespOk   = 8'h4B;
   localparam logic [7:0] RespErr  = 8'h45;

   typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS, RESP} state_t;

   state_t            state_q;
   logic              cyc_q;
   logic              stb_q;
   logic              we_q;
   logic              err_q;
   logic [31:0]       adr_q;
   logic [31:0]       dat_q;
   logic [31:0]       rdata_q;
   logic [1:0]        cnt_q;
   logic [BusW-1:0]   bus_cnt_q;
   logic [GapW-1:0]   gap_q;
   logic              tx_valid_q;
   logic [7:0]        tx_data_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         cyc_q      <= 1'b0;
         stb_q      <= 1'b0;
         we_q       <= 1'b0;
         err_q      <= 1'b0;
         adr_q      <= '0;
         dat_q      <= '0;
         rdata_q    <= '0;
         cnt_q      <= '0;
         bus_cnt_q  <= '0;
         gap_q      <= '0;
         tx_valid_q <= 1'b0;
         tx_data_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (rx_valid_i && (rx_data_i == CmdWrite || rx_data_i == CmdRead)) begin
                  we_q    <= (rx_data_i == CmdWrite);
                  err_q   <= 1'b0;
                  cnt_q   <= '0;
                  gap_q   <= '0;
                  state_q <= ADDR;
               end
            end
            ADDR: begin
               if (rx_valid_i) begin
                  adr_q <= {adr_q[23:0], rx_data_i};
                  gap_q <= '0;
                  cnt_q <= cnt_q + 2'd1;
                  if (cnt_q == 2'd3) begin
                     if (we_q) begin
                        state_q <= DATA;
                     end else begin
                        state_q   <= BUS;
                        cyc_q     <= 1'b1;
                        stb_q     <= 1'b1;
                        bus_cnt_q <= '0;
                     end
                  end
               end else if (gap_q == GapW'(BYTE_TIMEOUT - 1)) begin
                  state_q <= IDLE;
               end else begin
                  gap_q <= gap_q + 1'b1;
               end
            end
            DATA: begin
               if (rx_valid_i) begin
                  dat_q <= {dat_q[23:0], rx_data_i};
                  gap_q <= '0;
                  cnt_q <= cnt_q + 2'd1;
                  if (cnt_q == 2'd3) begin
                     state_q   <= BUS;
                     cyc_q     <= 1'b1;
                     stb_q     <= 1'b1;
                     bus_cnt_q <= '0;
                  end
               end else if (gap_q == GapW'(BYTE_TIMEOUT - 1)) begin
                  state_q <= IDLE;
               end else begin
                  gap_q <= gap_q + 1'b1;
               end
            end
            BUS: begin
               // ack is checked first so it wins over a timeout expiring in the same cycle
               if (wb_ack_i) begin
                  cyc_q      <= 1'b0;
                  stb_q      <= 1'b0;
                  cnt_q      <= '0;
                  tx_valid_q <= 1'b1;
                  state_q    <= RESP;
                  if (we_q) begin
                     tx_data_q <= RespOk;
                  end else begin
                     rdata_q   <= wb_dat_i;
                     tx_data_q <= wb_dat_i[31:24];
                  end
               end else if (bus_cnt_q == BusW'(BUS_TIMEOUT - 1)) begin
                  cyc_q      <= 1'b0;
                  stb_q      <= 1'b0;
                  err_q      <= 1'b1;
                  cnt_q      <= '0;
                  tx_valid_q <= 1'b1;
                  tx_data_q  <= RespErr;
                  state_q    <= RESP;
               end else begin
                  bus_cnt_q <= bus_cnt_q + 1'b1;
               end
            end
            RESP: begin
               if (tx_ready_i) begin
                  if (we_q || err_q || cnt_q == 2'd3) begin
                     tx_valid_q <= 1'b0;
                     state_q    <= IDLE;
                  end else begin
                     cnt_q <= cnt_q + 2'd1;
                     case (cnt_q)
                        2'd0:    tx_data_q <= rdata_q[23:16];
                        2'd1:    tx_data_q <= rdata_q[15:8];
                        default: tx_data_q <= rdata_q[7:0];
                     endcase
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign wb_cyc_o   = cyc_q;
   assign wb_stb_o   = stb_q;
   assign wb_we_o    = we_q;
   assign wb_sel_o   = 4'hF;
   assign wb_adr_o   = {adr_q[31:2], 2'b00};
   assign wb_dat_o   = dat_q;
   assign tx_valid_o = tx_valid_q;
   assign tx_data_o  = tx_data_q;
   assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_wb_serial_master.sv
// Directed bench for wb_serial_master: behavioural Wishbone slave, tx sink with optional
// backpressure, and monitors that record bus cycles, strobe length and transmitted bytes.
module tb_wb_serial_master;

   localparam int BusTo  = 16;
   localparam int ByteTo = 40;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        wbCyc, wbStb, wbWe, wbAck;
   logic [3:0]  wbSel;
   logic [31:0] wbAdr, wbDatO, wbDatI;
   logic        rxValid;
   logic [7:0]  rxData;
   logic        txValid, txReady;
   logic [7:0]  txData;
   logic        busy;

   int checks = 0;
   int failures = 0;

   // slave and sink controls
   logic        ackEnable = 1'b1;
   int          ackDelay = 0;
   logic [31:0] slaveData = 32'h0;
   int          waitCnt = 0;
   logic        bpMode = 1'b0;
   int          bpCnt = 0;

   // monitor state
   logic [7:0]  txQ[$];
   int          stbCount = 0;
   int          busCycles = 0;
   int          stableErr = 0;
   int          latErr = 0;
   logic        prevStb = 1'b0;
   logic        pendTx = 1'b0;
   logic [7:0]  pendData = 8'h0;
   logic        ackPrev = 1'b0;
   logic        lastWe = 1'b0;
   logic [31:0] lastAdr = 32'h0;
   logic [31:0] lastDat = 32'h0;

   wb_serial_master #(.BUS_TIMEOUT(BusTo), .BYTE_TIMEOUT(ByteTo)) dut (
      .clk_i(clk), .rst_i(rst),
      .wb_cyc_o(wbCyc), .wb_stb_o(wbStb), .wb_we_o(wbWe), .wb_sel_o(wbSel),
      .wb_adr_o(wbAdr), .wb_dat_o(wbDatO), .wb_dat_i(wbDatI), .wb_ack_i(wbAck),
      .rx_valid_i(rxValid), .rx_data_i(rxData),
      .tx_valid_o(txValid), .tx_data_o(txData), .tx_ready_i(txReady),
      .busy_o(busy)
   );

   always #5 clk = ~clk;

   // Slave: acks after ackDelay extra cycles of stb, for exactly one cycle
   always @(posedge clk) begin
      #1;
      wbAck = 1'b0;
      if (wbCyc && wbStb && ackEnable) begin
         if (waitCnt == ackDelay) begin
            wbAck = 1'b1;
            wbDatI = slaveData;
            waitCnt = 0;
         end else begin
            waitCnt++;
         end
      end else begin
         waitCnt = 0;
      end
   end

   // Tx sink: always ready, or a one-cycle ready pulse after ten stalled cycles per byte
   always @(posedge clk) begin
      #1;
      if (!bpMode) begin
         txReady = 1'b1;
      end else if (txReady) begin
         txReady = 1'b0;
         bpCnt = 0;
      end else if (txValid) begin
         if (bpCnt == 9) txReady = 1'b1;
         else bpCnt++;
      end
   end

   // Monitors sample mid-cycle
   always @(negedge clk) begin
      if (rst) begin
         prevStb = 1'b0;
         pendTx = 1'b0;
         ackPrev = 1'b0;
      end else begin
         if (wbStb) begin
            stbCount++;
            lastWe = wbWe;
            lastAdr = wbAdr;
            lastDat = wbDatO;
            if (!prevStb) busCycles++;
         end
         prevStb = wbStb;
         if (pendTx && (!txValid || txData != pendData)) stableErr++;
         pendTx = txValid && !txReady;
         pendData = txData;
         if (txValid && txReady) txQ.push_back(txData);
         if (ackPrev && (wbStb || wbCyc || !txValid)) latErr++;
         ackPrev = wbAck && wbStb;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("[TB] FAIL %s got=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] b);
      @(posedge clk);
      #1;
      rxValid = 1'b1;
      rxData = b;
      @(posedge clk);
      #1;
      rxValid = 1'b0;
   endtask

   task automatic clearMon();
      txQ.delete();
      stbCount = 0;
      busCycles = 0;
      stableErr = 0;
      latErr = 0;
   endtask

   task automatic waitIdle(input string tag, input int bound);
      int n = 0;
      while (busy && n < bound) begin
         @(negedge clk);
         n++;
      end
      checkOutput(tag, {31'd0, busy}, 32'd0);
   endtask

   task automatic checkTx(input string tag, input int n, input logic [31:0] exp);
      checkOutput({tag, "_len"}, 32'(txQ.size()), 32'(n));
      for (int i = 0; i < n && i < txQ.size(); i++)
         checkOutput($sformatf("%s_b%0d", tag, i), {24'd0, txQ[i]}, {24'd0, exp[8*(n-1-i) +: 8]});
   endtask

   initial begin
      rxValid = 1'b0;
      rxData = 8'h0;
      txReady = 1'b1;
      wbAck = 1'b0;
      wbDatI = 32'h0;

      // Reset state
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_cyc", {31'd0, wbCyc}, 32'd0);
      checkOutput("rst_stb", {31'd0, wbStb}, 32'd0);
      checkOutput("rst_we", {31'd0, wbWe}, 32'd0);
      checkOutput("rst_sel", {28'd0, wbSel}, 32'hF);
      checkOutput("rst_adr", wbAdr, 32'h0);
      checkOutput("rst_dat", wbDatO, 32'h0);
      checkOutput("rst_txv", {31'd0, txValid}, 32'd0);
      checkOutput("rst_txd", {24'd0, txData}, 32'd0);
      checkOutput("rst_busy", {31'd0, busy}, 32'd0);
      rst = 1'b0;

      // Write frame
      clearMon();
      ackEnable = 1'b1;
      ackDelay = 2;
      applyStimulus(8'h57);
      checkOutput("wr_busy", {31'd0, busy}, 32'd1);
      applyStimulus(8'h00); applyStimulus(8'h00); applyStimulus(8'h30); applyStimulus(8'h00);
      applyStimulus(8'h12); applyStimulus(8'h34); applyStimulus(8'h56); applyStimulus(8'h78);
      checkOutput("wr_stb_lat", {31'd0, wbStb}, 32'd1);
      checkOutput("wr_cyc", {31'd0, wbCyc}, 32'd1);
      checkOutput("wr_we", {31'd0, wbWe}, 32'd1);
      checkOutput("wr_adr", wbAdr, 32'h0000_3000);
      checkOutput("wr_dat", wbDatO, 32'h1234_5678);
      checkOutput("wr_sel", {28'd0, wbSel}, 32'hF);
      waitIdle("wr_idle", 200);
      checkTx("wr_tx", 1, 32'h4B);
      checkOutput("wr_stbcnt", 32'(stbCount), 32'd3);
      checkOutput("wr_cycles", 32'(busCycles), 32'd1);
      checkOutput("wr_lat", 32'(latErr), 32'd0);

      // Read frame
      clearMon();
      ackDelay = 0;
      slaveData = 32'hDEAD_BEEF;
      applyStimulus(8'h52); applyStimulus(8'h00); applyStimulus(8'h00);
      applyStimulus(8'hC0); applyStimulus(8'h04);
      checkOutput("rd_stb_lat", {31'd0, wbStb}, 32'd1);
      checkOutput("rd_adr", wbAdr, 32'h0000_C004);
      checkOutput("rd_we", {31'd0, wbWe}, 32'd0);
      waitIdle("rd_idle", 200);
      checkTx("rd_tx", 4, 32'hDEAD_BEEF);
      checkOutput("rd_lat", 32'(latErr), 32'd0);

      // Read with tx backpressure and an unaligned host address
      clearMon();
      bpMode = 1'b1;
      slaveData = 32'h0BAD_F00D;
      applyStimulus(8'h52); applyStimulus(8'h00); applyStimulus(8'h00);
      applyStimulus(8'h00); applyStimulus(8'h13);
      checkOutput("bp_adr", wbAdr, 32'h0000_0010);
      waitIdle("bp_idle", 300);
      checkTx("bp_tx", 4, 32'h0BAD_F00D);
      checkOutput("bp_stable", 32'(stableErr), 32'd0);
      bpMode = 1'b0;
      @(posedge clk);

      // Bus timeout, with a stray 'W' arriving during the bus cycle
      clearMon();
      ackEnable = 1'b0;
      applyStimulus(8'h52); applyStimulus(8'h00); applyStimulus(8'h00);
      applyStimulus(8'h00); applyStimulus(8'h40);
      applyStimulus(8'h57);
      waitIdle("to_idle", 200);
      checkOutput("to_stbcnt", 32'(stbCount), 32'(BusTo));
      checkTx("to_tx", 1, 32'h45);
      checkOutput("to_cycles", 32'(busCycles), 32'd1);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("to_stray", {31'd0, busy}, 32'd0);

      // Ack on the same cycle the timeout expires
      clearMon();
      ackEnable = 1'b1;
      ackDelay = BusTo - 1;
      applyStimulus(8'h57); applyStimulus(8'h00); applyStimulus(8'h00);
      applyStimulus(8'h00); applyStimulus(8'h80);
      applyStimulus(8'hA5); applyStimulus(8'h5A); applyStimulus(8'hA5); applyStimulus(8'h5A);
      waitIdle("edge_idle", 200);
      checkOutput("edge_stbcnt", 32'(stbCount), 32'(BusTo));
      checkTx("edge_tx", 1, 32'h4B);
      ackDelay = 0;

      // Garbage bytes then a stalled frame
      clearMon();
      applyStimulus(8'h00);
      applyStimulus(8'hFF);
      checkOutput("gb_busy", {31'd0, busy}, 32'd0);
      applyStimulus(8'h52); applyStimulus(8'h00); applyStimulus(8'h00);
      repeat (ByteTo - 1) @(posedge clk);
      #1;
      checkOutput("st_busy_before", {31'd0, busy}, 32'd1);
      @(posedge clk);
      #1;
      checkOutput("st_busy_after", {31'd0, busy}, 32'd0);
      repeat (3) @(posedge clk);
      checkOutput("st_cycles", 32'(busCycles), 32'd0);
      checkOutput("st_tx", 32'(txQ.size()), 32'd0);

      // Reset while the bus cycle is in progress, then a normal write
      clearMon();
      ackEnable = 1'b0;
      applyStimulus(8'h52); applyStimulus(8'h00); applyStimulus(8'h00);
      applyStimulus(8'h00); applyStimulus(8'h20);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("mr_stb_pre", {31'd0, wbStb}, 32'd1);
      rst = 1'b1;
      #1;
      checkOutput("mr_cyc", {31'd0, wbCyc}, 32'd0);
      checkOutput("mr_stb", {31'd0, wbStb}, 32'd0);
      checkOutput("mr_txv", {31'd0, txValid}, 32'd0);
      checkOutput("mr_busy", {31'd0, busy}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      clearMon();
      ackEnable = 1'b1;
      applyStimulus(8'h57); applyStimulus(8'h10); applyStimulus(8'h00);
      applyStimulus(8'h00); applyStimulus(8'h08);
      applyStimulus(8'hCA); applyStimulus(8'hFE); applyStimulus(8'hF0); applyStimulus(8'h0D);
      waitIdle("mr_idle", 200);
      checkOutput("mr_adr", lastAdr, 32'h1000_0008);
      checkOutput("mr_dat", lastDat, 32'hCAFE_F00D);
      checkOutput("mr_we", {31'd0, lastWe}, 32'd1);
      checkTx("mr_tx", 1, 32'h4B);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog got=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
